stack_responder: RTL
====================

Name: stack_responder

Overview:
- Hardware operand stack that services the controller's push/pop/tos command strobes for the stack-machine datapath.
- Stores pushed data, returns the popped or top-of-stack value one cycle later with a valid strobe, and tracks occupancy.
- Reports overflow/underflow as sticky error flags.
- Sits between the controller's stack command outputs and the datapath's A/B operand registers.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- CW, 5, width of count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  push din this cycle.
- pop  input  1  remove the top entry and return it on dout.
- tos  input  1  return the top entry on dout without removing it.
- din  input  WIDTH  data to push.
- err_clr  input  1  synchronous clear of the sticky error flags.
- dout  output  WIDTH  returned data, registered.
- dout_valid  output  1  one-cycle strobe: dout updated this cycle.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  CW  number of stored entries.
- overflow  output  1  sticky: push was refused.
- underflow  output  1  sticky: pop or tos was issued while empty.

Behaviour:
- Reset (rst low, asynchronous):
  - count=0, stack pointer sp=0, dout=0, dout_valid=0, overflow=0, underflow=0.
  - empty=1, full=0.
  - Storage contents are not reset and are don't-care.
- Storage: DEPTH x WIDTH register array. sp points to the next free slot; the top entry is mem[sp-1]. Array writes are synchronous on rising clk.
- Per-cycle decode, evaluated on registered state at the rising edge:
  - Push only:
    - not full: mem[sp]<=din, sp+1, count+1.
    - full: no write, no change, overflow<=1.
  - Pop only:
    - not empty: dout<=mem[sp-1], dout_valid<=1, sp-1, count-1.
    - empty: underflow<=1, dout held, dout_valid<=0.
  - Tos only:
    - not empty: dout<=mem[sp-1], dout_valid<=1, no pointer change.
    - empty: underflow<=1, dout_valid<=0.
  - Push and pop together:
    - not empty: dout<=old mem[sp-1], mem[sp-1]<=din, dout_valid<=1; sp and count unchanged. This applies when full as well, with no overflow.
    - empty: the pop is refused (underflow<=1, dout_valid<=0) and the push proceeds normally.
  - Tos together with pop: the pop takes effect; tos is ignored.
  - Tos together with push:
    - not empty: dout<=mem[sp-1] from before the push, and the push proceeds (or is refused if full, with overflow set).
    - empty: underflow<=1, and the push proceeds.
  - No command: dout holds, dout_valid<=0.
- Latency: data is visible on dout exactly 1 cycle after the command edge. There is no back-to-back stall; a new command may be issued every cycle. A pop on cycle n followed by a pop on cycle n+1 returns successive entries.
- Pointer arithmetic:
  - sp is log2(DEPTH) bits and wraps modulo DEPTH. sp=0 with count=DEPTH is full; sp=0 with count=0 is empty.
  - count is the only full/empty discriminator.
- Errors:
  - overflow and underflow set on the refusing edge and stay set until err_clr or reset.
  - err_clr in the same cycle as a new error: set wins.
  - Refused operations never modify sp, count, or storage.
- Outputs empty, full, and count are combinational from the registered count; they have no glitch requirement beyond that.
- Reset asserted mid-sequence discards all entries immediately. The first command after rst deasserts sees an empty stack.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, empty=0; then pop x3 -> dout 0x33, 0x22, 0x11, each with dout_valid high 1 cycle after its pop; final count=0, empty=1.
- Push 0x5A, then tos twice -> dout=0x5A with dout_valid both cycles, count stays 1; then pop -> dout=0x5A, count=0.
- Push 16 values 0x00..0x0F -> full=1, count=16; push 0xFF -> overflow=1, count=16; pop -> dout=0x0F (not 0xFF).
- Fill to 16, then push 0xAA with pop on the same cycle -> dout=0x0F, count=16, overflow=0; next pop -> dout=0xAA.
- Empty stack: pop -> underflow=1, dout_valid=0, count=0; push+pop together with din=0x77 -> count=1, underflow stays 1; err_clr -> underflow=0; pop -> dout=0x77.
- Push 4 entries, assert rst low asynchronously between clock edges -> count=0, dout=0, dout_valid=0 immediately; after release, pop -> underflow=1.

Source files
------------

// File: rtl/stack_responder_if.sv
// Command/response bundle between the stack-machine controller and the
// operand stack. The controller drives commands and data (master); the stack
// returns data, the valid strobe, occupancy and the sticky error flags (slave).
interface stack_responder_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
);
    logic             push;
    logic             pop;
    logic             tos;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, tos, din, err_clr,
        input  dout, dout_valid, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, tos, din, err_clr,
        output dout, dout_valid, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/stack_responder.sv
// Hardware operand stack for the stack-machine datapath. Push writes the
// next free slot; pop/tos return the top entry on dout one cycle after the
// command with a one-cycle valid strobe. A simultaneous push+pop replaces the
// top entry in place. Overflow/underflow are sticky until err_clr or reset.
module stack_responder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input logic               clk,
    input logic               rst,
    stack_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    sp;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_p1;
    logic             vld_p1;
    logic             overflow_q;
    logic             underflow_q;

    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    sp_top;
    logic [WIDTH-1:0] top_data;
    logic             do_pop;
    logic             do_tos;
    logic             do_push;
    logic             do_swap;
    logic             push_refused;
    logic             read_refused;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign sp_top   = sp - AW'(1);
    assign top_data = mem[sp_top];

    // Command decode on registered state; pop outranks tos, and a push
    // alongside a successful pop becomes an in-place replace of the top.
    always_comb begin
        do_pop       = bus.pop && !is_empty;
        do_tos       = bus.tos && !bus.pop && !is_empty;
        do_swap      = bus.push && do_pop;
        do_push      = bus.push && !do_pop && !is_full;
        push_refused = bus.push && !bus.pop && is_full;
        read_refused = (bus.pop || bus.tos) && is_empty;
    end

    // Storage array: written on push (next free slot) or replace (top slot).
    always_ff @(posedge clk) begin
        if (do_swap) begin
            mem[sp_top] <= bus.din;
        end else if (do_push) begin
            mem[sp] <= bus.din;
        end
    end

    // Stack pointer and occupancy; a replace leaves both unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp      <= '0;
            count_q <= '0;
        end else if (do_push) begin
            sp      <= sp + AW'(1);
            count_q <= count_q + CW'(1);
        end else if (do_pop && !do_swap) begin
            sp      <= sp_top;
            count_q <= count_q - CW'(1);
        end
    end

    // Registered read port: dout holds between reads, valid strobes once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= do_pop || do_tos;
            if (do_pop || do_tos) begin
                dout_p1 <= top_data;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_refused) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (read_refused) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_p1;
    assign bus.dout_valid = vld_p1;
    assign bus.empty      = is_empty;
    assign bus.full       = is_full;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule
